// File: rtl/bist_misr_compactor_if.sv
// bist_misr_compactor_if: run request, sampled result word, and signature/status outputs of the compactor
interface bist_misr_compactor_if;
  logic        start;
  logic [3:0]  result_in;
  logic [3:0]  sig_out;
  logic [15:0] sample_cnt;
  logic        busy;
  logic        done;
  logic        pass;
  modport master (output start, result_in, input sig_out, sample_cnt, busy, done, pass);
  modport slave (input start, result_in, output sig_out, sample_cnt, busy, done, pass);
endinterface

// File: rtl/bist_misr_compactor.sv
// bist_misr_compactor: compacts N_CYCLES result words into a 4-bit MISR and flags pass vs GOLDEN (ports: clk, rst, bus.slave)
module bist_misr_compactor #(
  parameter logic [15:0] N_CYCLES = 16'd255,
  parameter logic [3:0] MISR_SEED = 4'h0,
  parameter logic [3:0] GOLDEN = 4'h0
) (
  input logic clk,
  input logic rst,
  bist_misr_compactor_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state;
  logic [3:0] r_misr;
  logic [15:0] r_cnt;
  logic r_busy, r_done, r_pass;
  logic [3:0] w_misr_next;
  logic [15:0] w_cnt_next;
  logic w_last;
  always_comb begin
    w_misr_next = {r_misr[2], r_misr[1], r_misr[0] ^ r_misr[3], r_misr[3]} ^ bus.result_in;
    w_cnt_next = r_cnt + 16'd1;
    w_last = w_cnt_next == N_CYCLES;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_misr <= MISR_SEED;
      r_cnt <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else if (r_state == RUN) begin
      r_misr <= w_misr_next;
      r_cnt <= w_cnt_next;
      if (w_last) begin
        r_state <= DONE;
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_pass <= w_misr_next == GOLDEN;
      end
    end else if (bus.start) begin
      r_state <= RUN;
      r_misr <= MISR_SEED;
      r_cnt <= '0;
      r_busy <= 1'b1;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end
  end
  assign bus.sig_out = r_misr;
  assign bus.sample_cnt = r_cnt;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.pass = r_pass;
endmodule
